// File: rtl/mtm_alu_response_deserializer.sv
// mtm_alu_response_deserializer
// Rebuilds the ALU result word C and the control byte CTL from the ALU serial
// output line. Each packet is: start(0), type(0=data,1=ctl), payload MSB first,
// stop(1). A data response is DATA_PACKETS data packets (MSB byte first)
// followed by one ctl packet. An error response is a lone ctl packet.
// Malformed frames are dropped and reported with a one-cycle frame_err pulse.

module mtm_alu_response_deserializer #(
  parameter int DATA_PACKETS = 4,
  parameter int PKT_BITS     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sin,
  output logic [DATA_PACKETS*PKT_BITS-1:0] C,
  output logic [PKT_BITS-1:0]              CTL,
  output logic                             out_valid,
  output logic                             is_error,
  output logic                             frame_err
);

  localparam int CW  = DATA_PACKETS * PKT_BITS;
  localparam int PCW = $clog2(DATA_PACKETS + 1);
  localparam int BCW = (PKT_BITS > 1) ? $clog2(PKT_BITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TYPE      = 3'd1,
    ST_PAYLOAD   = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 type_q, type_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PKT_BITS-1:0]  shift_q, shift_d;
  logic [PCW-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [CW-1:0]        shadow_q, shadow_d;
  logic [CW-1:0]        c_q, c_d;
  logic [PKT_BITS-1:0]  ctl_q, ctl_d;
  logic                 is_error_q, is_error_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_err_q, frame_err_d;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: walk the packet fields, park in WAIT_IDLE after a bad stop bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!sin) begin
          state_d = ST_TYPE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TYPE: begin
        state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (bit_cnt_q == BCW'(0)) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_STOP: begin
        if (!sin) begin
          state_d = ST_WAIT_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (sin) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and output next values: shift payload, collect data bytes, resolve the packet at the stop bit.
  always_comb begin
    type_d      = type_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    pkt_cnt_d   = pkt_cnt_q;
    shadow_d    = shadow_q;
    c_d         = c_q;
    ctl_d       = ctl_q;
    is_error_d  = is_error_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_TYPE: begin
        type_d    = sin;
        bit_cnt_d = BCW'(PKT_BITS - 1);
      end
      ST_PAYLOAD: begin
        shift_d = {shift_q[PKT_BITS-2:0], sin};
        if (bit_cnt_q != BCW'(0)) begin
          bit_cnt_d = bit_cnt_q - BCW'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      ST_STOP: begin
        if (!sin) begin
          // Broken stop bit: drop whatever response was in progress.
          frame_err_d = 1'b1;
          pkt_cnt_d   = PCW'(0);
        end else if (!type_q) begin
          if (pkt_cnt_q < PCW'(DATA_PACKETS)) begin
            // Slot 0 is the most significant byte of C.
            for (int i = 0; i < DATA_PACKETS; i++) begin
              shadow_d[CW-1-PKT_BITS*i -: PKT_BITS] = (pkt_cnt_q == PCW'(i)) ?
                  shift_q : shadow_q[CW-1-PKT_BITS*i -: PKT_BITS];
            end
            pkt_cnt_d = pkt_cnt_q + PCW'(1);
          end else begin
            // One data packet too many.
            frame_err_d = 1'b1;
            pkt_cnt_d   = PCW'(0);
          end
        end else begin
          if (pkt_cnt_q == PCW'(DATA_PACKETS)) begin
            c_d         = shadow_q;
            ctl_d       = shift_q;
            is_error_d  = 1'b0;
            out_valid_d = 1'b1;
          end else if (pkt_cnt_q == PCW'(0)) begin
            ctl_d       = shift_q;
            is_error_d  = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            // Ctl packet arrived before all data bytes.
            frame_err_d = 1'b1;
          end
          pkt_cnt_d = PCW'(0);
        end
      end
      default: begin
        type_d = type_q;
      end
    endcase
  end

  // Datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      type_q      <= 1'b0;
      bit_cnt_q   <= BCW'(0);
      shift_q     <= PKT_BITS'(0);
      pkt_cnt_q   <= PCW'(0);
      shadow_q    <= CW'(0);
      c_q         <= CW'(0);
      ctl_q       <= PKT_BITS'(0);
      is_error_q  <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      type_q      <= type_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pkt_cnt_q   <= pkt_cnt_d;
      shadow_q    <= shadow_d;
      c_q         <= c_d;
      ctl_q       <= ctl_d;
      is_error_q  <= is_error_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign C         = c_q;
  assign CTL       = ctl_q;
  assign out_valid = out_valid_q;
  assign is_error  = is_error_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mtm_alu_response_deserializer.sv
// Bench for mtm_alu_response_deserializer: directed scenarios followed by
// random response streams, compared every cycle against a packet-level model.

module tb_mtm_alu_response_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] C;
  logic [7:0]  CTL;
  logic        out_valid;
  logic        is_error;
  logic        frame_err;

  int total = 0;
  int bad   = 0;

  // Packet-level reference model state.
  logic [31:0] m_c;
  logic [7:0]  m_ctl;
  logic        m_iserr;
  int          m_cnt;
  logic [7:0]  m_bytes [4];
  logic        exp_v;
  logic        exp_f;
  bit          need_idle;

  always #5 clk = ~clk;

  mtm_alu_response_deserializer #(.DATA_PACKETS(4), .PKT_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .C         (C),
    .CTL       (CTL),
    .out_valid (out_valid),
    .is_error  (is_error),
    .frame_err (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    check("frame_err", {31'd0, frame_err}, {31'd0, exp_f});
    check("C", C, m_c);
    check("CTL", {24'd0, CTL}, {24'd0, m_ctl});
    check("is_error", {31'd0, is_error}, {31'd0, m_iserr});
  endtask

  // Drive one line bit for one clock, then compare after the edge.
  task automatic tick(input logic b);
    sin = b;
    @(posedge clk);
    #1;
    check_outputs();
    exp_v = 1'b0;
    exp_f = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
    if (n > 0) need_idle = 1'b0;
  endtask

  // Outcome of a complete packet, decided from the response rules.
  task automatic apply_model(input logic t, input logic [7:0] b, input logic stop);
    if (!stop) begin
      exp_f = 1'b1;
      m_cnt = 0;
    end else if (!t) begin
      if (m_cnt < 4) begin
        m_bytes[m_cnt] = b;
        m_cnt++;
      end else begin
        exp_f = 1'b1;
        m_cnt = 0;
      end
    end else begin
      if (m_cnt == 4) begin
        m_c     = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
        m_ctl   = b;
        m_iserr = 1'b0;
        exp_v   = 1'b1;
      end else if (m_cnt == 0) begin
        m_ctl   = b;
        m_iserr = 1'b1;
        exp_v   = 1'b1;
      end else begin
        exp_f = 1'b1;
      end
      m_cnt = 0;
    end
  endtask

  task automatic send_pkt(input logic t, input logic [7:0] b, input logic stop);
    tick(1'b0);
    tick(t);
    for (int i = 7; i >= 0; i--) tick(b[i]);
    apply_model(t, b, stop);
    tick(stop);
    if (!stop) need_idle = 1'b1;
  endtask

  task automatic send_data_resp(input logic [31:0] c, input logic [7:0] ctl);
    for (int i = 0; i < 4; i++) send_pkt(1'b0, c[31-8*i -: 8], 1'b1);
    send_pkt(1'b1, ctl, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sin = 1'b1;
    @(posedge clk);
    #1;
    m_c = 32'd0; m_ctl = 8'd0; m_iserr = 1'b0; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_bytes[i] = 8'd0;
    exp_v = 1'b0; exp_f = 1'b0;
    check_outputs();
    rst = 1'b0;
    need_idle = 1'b0;
  endtask

  initial begin
    int r;
    int k;
    rst = 1'b1;
    sin = 1'b1;
    exp_v = 1'b0;
    exp_f = 1'b0;
    need_idle = 1'b0;
    do_reset();
    do_reset();
    idle(3);

    // Basic data response.
    send_data_resp(32'h12345678, 8'h2A);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_c", C, 32'h12345678);
    check("t1_ctl", {24'd0, CTL}, 32'h2A);

    // Two error responses back-to-back.
    send_pkt(1'b1, 8'hC9, 1'b1);
    check("t2_err1", {31'd0, is_error}, 32'd1);
    check("t2_ctl1", {24'd0, CTL}, 32'hC9);
    send_pkt(1'b1, 8'h93, 1'b1);
    check("t2_ctl2", {24'd0, CTL}, 32'h93);
    check("t2_c_held", C, 32'h12345678);

    // Two data responses back-to-back.
    send_data_resp(32'hFFFFFFFF, 8'h0F);
    check("t3_c1", C, 32'hFFFFFFFF);
    send_data_resp(32'h00000001, 8'h01);
    check("t3_c2", C, 32'h00000001);
    check("t3_err", {31'd0, is_error}, 32'd0);

    // Stop violation in packet 2, line stuck low, then recovery.
    idle(2);
    send_pkt(1'b0, 8'hAA, 1'b1);
    send_pkt(1'b0, 8'hBB, 1'b0);
    check("t4_ferr", {31'd0, frame_err}, 32'd1);
    for (int i = 0; i < 20; i++) tick(1'b0);
    idle(2);
    send_pkt(1'b1, 8'h5A, 1'b1);
    check("t4_ctl", {24'd0, CTL}, 32'h5A);

    // Ctl packet after only two data packets.
    send_pkt(1'b0, 8'h11, 1'b1);
    send_pkt(1'b0, 8'h22, 1'b1);
    send_pkt(1'b1, 8'h2A, 1'b1);
    check("t5_ferr", {31'd0, frame_err}, 32'd1);
    check("t5_ctl_held", {24'd0, CTL}, 32'h5A);
    send_data_resp(32'hCAFEBABE, 8'h33);
    check("t5_c", C, 32'hCAFEBABE);

    // Reset in the middle of packet 3.
    send_pkt(1'b0, 8'h77, 1'b1);
    send_pkt(1'b0, 8'h66, 1'b1);
    tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
    do_reset();
    check("t6_c_zero", C, 32'd0);
    idle(2);
    send_data_resp(32'hDEADBEEF, 8'h44);
    check("t6_c", C, 32'hDEADBEEF);

    // Random response streams.
    for (int it = 0; it < 150; it++) begin
      if (need_idle) idle(1 + $urandom_range(0, 2));
      else           idle($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: send_data_resp($urandom, 8'($urandom));
        4, 5:       send_pkt(1'b1, 8'($urandom), 1'b1);
        6: begin
          k = $urandom_range(0, 4);
          for (int i = 0; i < k; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
          send_pkt(1'($urandom), 8'($urandom), 1'b0);
          k = $urandom_range(0, 5);
          for (int i = 0; i < k; i++) tick(1'b0);
        end
        7: begin
          k = $urandom_range(1, 3);
          for (int i = 0; i < k; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
          send_pkt(1'b1, 8'($urandom), 1'b1);
        end
        8: begin
          for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
          send_pkt(1'b1, 8'($urandom), 1'b1);
        end
        default: begin
          k = $urandom_range(0, 3);
          for (int i = 0; i < k; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
          tick(1'b0);
          k = $urandom_range(1, 9);
          for (int i = 0; i < k; i++) tick(1'($urandom));
          do_reset();
        end
      endcase
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtm_alu_response_deserializer.md
Name: mtm_alu_response_deserializer

Overview:
- Receives the ALU result serial stream and rebuilds the 32-bit result C and the 8-bit control/status byte CTL.
- Sits on the host/bench side of the ALU output line, or in front of a result checker.
- Decodes the packet format the ALU serializer emits: one bit per clk, no oversampling.
- Raises a one-cycle valid pulse per complete response, and a one-cycle error pulse per malformed frame.

Parameters:
- DATA_PACKETS, 4, number of data packets preceding the CTL packet in a data response; bytes arrive MSB byte first.
- PKT_BITS, 8, payload bits per packet; transmitted MSB first.

Ports:
- clk  input  1  single clock; sin is sampled on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial line; idles at 1.
- C  output  32  last received result; held until the next data response.
- CTL  output  8  last received control byte; held until the next response.
- out_valid  output  1  one-cycle pulse: C/CTL updated with a complete response.
- is_error  output  1  qualifies out_valid: 1 = CTL-only (error) response, 0 = data response.
- frame_err  output  1  one-cycle pulse: malformed frame detected and discarded.

Behaviour:
- Packet: start 0, type bit (0 = data, 1 = ctl), PKT_BITS payload MSB first, stop 1. That is 11 clk per packet.
- Packets may be back-to-back: the start bit of the next packet may immediately follow a stop bit.
- Data response: DATA_PACKETS data packets (C[31:24] first), then one ctl packet; 55 clk total.
- Error response: a single ctl packet.
- Reset: rst is sampled high at a clk edge. State goes to IDLE, counters clear, the shift register and shadow C clear. C=0, CTL=0, out_valid=0, is_error=0, frame_err=0. Reset mid-frame discards the partial frame; no pulse is generated.
- IDLE: sin=1 keeps IDLE. sin=0 is the start bit and moves to TYPE.
- TYPE: sample the type bit; load bit_cnt=PKT_BITS-1; go to PAYLOAD.
- PAYLOAD: shift sin into an 8-bit register MSB first and decrement bit_cnt. After the bit sampled with bit_cnt=0, go to STOP.
- STOP, sin=0 (stop violation): pulse frame_err next cycle; clear pkt_cnt; go to WAIT_IDLE.
- STOP, sin=1, type=data, pkt_cnt<DATA_PACKETS: store byte into shadow C slot [31-8*pkt_cnt -: 8]; pkt_cnt++; go to IDLE.
- STOP, sin=1, type=data, pkt_cnt==DATA_PACKETS: frame_err pulse; clear pkt_cnt; go to IDLE.
- STOP, sin=1, type=ctl, pkt_cnt==DATA_PACKETS: C<=shadow; CTL<=byte; is_error<=0; out_valid pulse.
- STOP, sin=1, type=ctl, pkt_cnt==0: CTL<=byte; C unchanged; is_error<=1; out_valid pulse.
- STOP, sin=1, type=ctl, 0<pkt_cnt<DATA_PACKETS: frame_err pulse; C/CTL unchanged.
- After any ctl packet: clear pkt_cnt; go to IDLE.
- Latency: out_valid and frame_err assert on the clk after the stop bit is sampled. This is the same cycle IDLE samples the next start bit.
- WAIT_IDLE: stay until sin=1 is sampled, then go to IDLE. This prevents a stuck-low line from producing garbage packets.
- out_valid and frame_err are never high in the same cycle.
- Outputs are registered: out_valid, is_error, frame_err, C and CTL all come from flops.
- The ctl byte content is not checked; CTL[7] is passed through unchanged.
- pkt_cnt width is clog2(DATA_PACKETS+1). bit_cnt width is clog2(PKT_BITS).
- No wrap-around: pkt_cnt never exceeds DATA_PACKETS.

Test Plan:
- Data response C=0x12345678, CTL=0x2A: 55-bit stream after idle ones -> out_valid pulse exactly 1 clk after the 55th bit, with C=0x12345678, CTL=0x2A, is_error=0.
- Error response CTL=0xC9, then CTL=0x93 back-to-back (no idle gap) -> two out_valid pulses 11 clk apart. is_error=1 on both, CTL=0xC9 then 0x93. C keeps its previous value 0x12345678.
- Two data responses back-to-back (0xFFFFFFFF/0x0F, then 0x00000001/0x01) -> pulses 55 clk apart. C/CTL match each response, and the second response shows no stale shadow bits.
- Stop bit forced to 0 in packet 2 of a data response, line then held at 0 for 20 clk, then a valid error response -> frame_err pulse once, no out_valid during the bad frame, stays in WAIT_IDLE while sin=0. The following error response then decodes normally.
- Ctl packet 0x2A after only 2 data packets -> frame_err pulse; out_valid stays 0; C/CTL unchanged. A following full data response decodes correctly.
- rst asserted for 1 clk in the middle of packet 3 -> all outputs 0 next cycle. A full data response sent after rst deasserts decodes with no spurious pulses.
